muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller for the EXE stage: latched operands, a fixed-latency
// multiply, a 32-cycle restoring divide, and registered HI/LO results.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  EXE_MulDivOp,
  input  logic [31:0] EXE_ResultA,
  input  logic [31:0] EXE_ResultB,
  input  logic        EXE_Flush,
  output logic        MulDiv_Stall,
  output logic        MulDiv_Done,
  output logic [31:0] MulDiv_HI,
  output logic [31:0] MulDiv_LO,
  output logic [31:0] MUL_Out
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        msig_q, msig_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul, is_div, div_signed, accept;
  logic [31:0] abs_a, abs_b;

  assign is_mul     = (EXE_MulDivOp == OP_MULT) || (EXE_MulDivOp == OP_MULTU) ||
                      (EXE_MulDivOp == OP_MUL);
  assign is_div     = (EXE_MulDivOp == OP_DIV) || (EXE_MulDivOp == OP_DIVU);
  assign div_signed = (EXE_MulDivOp == OP_DIV);
  assign accept     = (state_q == IDLE) && (is_mul || is_div) && !EXE_Flush;

  // The divider works on magnitudes; signs are reapplied when the result is written.
  assign abs_a = (div_signed && EXE_ResultA[31]) ? -EXE_ResultA : EXE_ResultA;
  assign abs_b = (div_signed && EXE_ResultB[31]) ? -EXE_ResultB : EXE_ResultB;

  // Multiplier reads the live operands only when MUL_LAT==1 completes in the accept cycle.
  logic [31:0] mul_a, mul_b;
  logic        mul_sgn;
  logic [63:0] ext_a, ext_b, product;

  assign mul_a   = (state_q == IDLE) ? EXE_ResultA : a_q;
  assign mul_b   = (state_q == IDLE) ? EXE_ResultB : b_q;
  assign mul_sgn = (state_q == IDLE) ? (EXE_MulDivOp != OP_MULTU) : msig_q;
  assign ext_a   = {{32{mul_sgn & mul_a[31]}}, mul_a};
  assign ext_b   = {{32{mul_sgn & mul_b[31]}}, mul_b};
  assign product = ext_a * ext_b;

  logic [32:0] div_shift;
  logic        div_fits;
  logic [31:0] rem_step, quo_step;

  assign div_shift = {rem_q, quo_q[31]};
  assign div_fits  = (div_shift >= {1'b0, b_q});
  assign rem_step  = div_fits ? 32'(div_shift - {1'b0, b_q}) : div_shift[31:0];
  assign quo_step  = {quo_q[30:0], div_fits};

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    msig_d  = msig_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d    = EXE_ResultA;
          msig_d = (EXE_MulDivOp != OP_MULTU);
          if (is_mul) begin
            b_d = EXE_ResultB;
            if (MUL_LAT <= 1) begin
              state_d = DONE;
              hi_d    = product[63:32];
              lo_d    = product[31:0];
            end else begin
              state_d = MUL;
              cnt_d   = 5'(MUL_LAT - 1);
            end
          end else begin
            b_d    = abs_b;
            quo_d  = abs_a;
            rem_d  = '0;
            cnt_d  = '0;
            qneg_d = div_signed && (EXE_ResultA[31] ^ EXE_ResultB[31]);
            rneg_d = div_signed && EXE_ResultA[31];
            if (EXE_ResultB == '0) begin
              state_d = DONE;
              hi_d    = EXE_ResultA;
              lo_d    = '1;
            end else begin
              state_d = DIV;
            end
          end
        end
      end

      MUL: begin
        if (EXE_Flush) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd1) begin
          state_d = DONE;
          hi_d    = product[63:32];
          lo_d    = product[31:0];
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      DIV: begin
        if (EXE_Flush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
            lo_d    = qneg_q ? -quo_step : quo_step;
            hi_d    = rneg_q ? -rem_step : rem_step;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the working registers are plain flops, so they are reset with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      msig_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      msig_q  <= msig_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign MulDiv_Stall = accept || (state_q == MUL) || (state_q == DIV);
  assign MulDiv_Done  = (state_q == DONE) && !EXE_Flush;
  assign MulDiv_HI    = hi_q;
  assign MulDiv_LO    = lo_q;
  assign MUL_Out      = lo_q;

endmodule
